// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
// Bundles the signals of the registered RV32I decode stage id_stage_pipe:
//   IF side      : in_valid/in_ready handshake, in_pc, in_inst, flush
//   regfile side : reg1/2_raddr out, reg1/2_rdata_i in, write-back port wb_*
//   EX side      : out_valid/out_ready handshake and the decoded payload
//                  (out_pc, alu_op, alu_src_sel, operands, imm_o, flags, rd)
//   status       : hazard_stall (combinational load-use stall)
// Modports:
//   slave  - the decode stage itself
//   master - the surroundings (IF, register file, write-back, EX)
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  // IF side
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            flush;
  // register file and write-back
  logic [4:0]      reg1_raddr;
  logic [4:0]      reg2_raddr;
  logic [XLEN-1:0] reg1_rdata_i;
  logic [XLEN-1:0] reg2_rdata_i;
  logic            wb_wen;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  // EX side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      alu_op;
  logic [1:0]      alu_src_sel;
  logic [XLEN-1:0] reg1_data_o;
  logic [XLEN-1:0] reg2_data_o;
  logic [XLEN-1:0] imm_o;
  logic            branch;
  logic            jump;
  logic            reg_wen;
  logic            mem_read;
  logic            mem_write;
  logic            ecall;
  logic            ebreak;
  logic            fence;
  logic            illegal;
  logic [4:0]      reg_waddr;
  logic            hazard_stall;

  modport slave (
    input  in_valid, in_pc, in_inst, flush,
    input  reg1_rdata_i, reg2_rdata_i, wb_wen, wb_waddr, wb_wdata,
    input  out_ready,
    output in_ready, reg1_raddr, reg2_raddr,
    output out_valid, out_pc, alu_op, alu_src_sel, reg1_data_o, reg2_data_o, imm_o,
    output branch, jump, reg_wen, mem_read, mem_write, ecall, ebreak, fence, illegal,
    output reg_waddr, hazard_stall
  );

  modport master (
    output in_valid, in_pc, in_inst, flush,
    output reg1_rdata_i, reg2_rdata_i, wb_wen, wb_waddr, wb_wdata,
    output out_ready,
    input  in_ready, reg1_raddr, reg2_raddr,
    input  out_valid, out_pc, alu_op, alu_src_sel, reg1_data_o, reg2_data_o, imm_o,
    input  branch, jump, reg_wen, mem_read, mem_write, ecall, ebreak, fence, illegal,
    input  reg_waddr, hazard_stall
  );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Registered RV32I decode stage between IF and EX.
//   - accepts one instruction per cycle on the in_valid/in_ready handshake
//   - reads the register file (rs1/rs2 addresses are combinational) and
//     optionally bypasses same-cycle write-back data
//   - registers the decoded ID/EX payload, presented with out_valid/out_ready
//   - stalls one cycle on a load-use hazard against its own output register
//   - flush kills both the input instruction and the output register
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : id_stage_pipe_if.slave (IF, register file, write-back, EX)
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter bit FWD_WB = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  id_stage_pipe_if.slave      bus
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    alu_op_e         alu_op;
    logic [1:0]      alu_src_sel;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            branch;
    logic            jump;
    logic            reg_wen;
    logic            mem_read;
    logic            mem_write;
    logic            ecall;
    logic            ebreak;
    logic            fence;
    logic            illegal;
    logic [4:0]      waddr;
  } payload_t;

  // funct3 -> ALU op; 'alt' is inst[30] (funct7[5] / imm[10]).
  // Only register-register ops use it to pick SUB; shifts use it in both forms.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic is_op);
    case (f3)
      3'b000:  return (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [31:0]     w_inst;
  opcode_e         w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic            w_rs1_used, w_rs2_used;
  logic            w_load_use;
  logic            w_accept;
  payload_t        w_dec;

  logic            r_valid;
  payload_t        r_pay;

  assign w_inst   = bus.in_inst;
  assign w_opcode = opcode_e'(w_inst[6:0]);
  assign w_rs1    = w_inst[19:15];
  assign w_rs2    = w_inst[24:20];
  assign w_rd     = w_inst[11:7];
  assign w_funct3 = w_inst[14:12];

  // Size-casting a signed value sign-extends it to XLEN.
  assign w_imm_i = XLEN'($signed(w_inst[31:20]));
  assign w_imm_s = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
  assign w_imm_b = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({w_inst[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));

  // Operand read with optional write-back bypass; x0 is hard-wired to zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    w_rs1_data = bus.reg1_rdata_i;
    w_rs2_data = bus.reg2_rdata_i;
    if (w_rs1 == 5'd0)
      w_rs1_data = '0;
    else if (FWD_WB && bus.wb_wen && (bus.wb_waddr == w_rs1))
      w_rs1_data = bus.wb_wdata;
    if (w_rs2 == 5'd0)
      w_rs2_data = '0;
    else if (FWD_WB && bus.wb_wen && (bus.wb_waddr == w_rs2))
      w_rs2_data = bus.wb_wdata;
  end

  // Decode. All legal opcodes end in 2'b11, so a bad low-bit pattern also
  // falls through to the illegal default.
  always_comb begin
    w_dec          = '0;
    w_dec.pc       = bus.in_pc;
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.waddr    = w_rd;
    case (w_opcode)
      OPC_OP: begin
        w_dec.alu_op  = alu_from_f3(w_funct3, w_inst[30], 1'b1);
        w_dec.reg_wen = 1'b1;
      end
      OPC_OPIMM: begin
        w_dec.alu_op      = alu_from_f3(w_funct3, w_inst[30], 1'b0);
        w_dec.alu_src_sel = 2'b01;
        w_dec.imm         = w_imm_i;
        w_dec.reg_wen     = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.alu_src_sel = 2'b01;
        w_dec.imm         = w_imm_i;
        w_dec.mem_read    = 1'b1;
        w_dec.reg_wen     = 1'b1;
      end
      OPC_STORE: begin
        w_dec.alu_src_sel = 2'b01;
        w_dec.imm         = w_imm_s;
        w_dec.mem_write   = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.imm    = w_imm_b;
        w_dec.branch = 1'b1;
      end
      OPC_LUI: begin
        w_dec.alu_op      = ALU_PASSB;
        w_dec.alu_src_sel = 2'b01;
        w_dec.imm         = w_imm_u;
        w_dec.reg_wen     = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.alu_src_sel = 2'b10;
        w_dec.imm         = w_imm_u;
        w_dec.reg_wen     = 1'b1;
      end
      OPC_JAL: begin
        w_dec.alu_src_sel = 2'b10;
        w_dec.imm         = w_imm_j;
        w_dec.jump        = 1'b1;
        w_dec.reg_wen     = 1'b1;
      end
      OPC_JALR: begin
        w_dec.alu_src_sel = 2'b01;
        w_dec.imm         = w_imm_i;
        w_dec.jump        = 1'b1;
        w_dec.reg_wen     = 1'b1;
      end
      OPC_FENCE:  w_dec.fence = 1'b1;
      OPC_SYSTEM: begin
        w_dec.ecall  = (w_inst[31:20] == 12'd0);
        w_dec.ebreak = (w_inst[31:20] == 12'd1);
      end
      default:    w_dec.illegal = 1'b1;
    endcase
    if (w_rd == 5'd0)
      w_dec.reg_wen = 1'b0;
  end

  // Register-use classification for the load-use check.
  assign w_rs1_used = !(w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM});
  assign w_rs2_used =   w_opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

  assign w_load_use = r_valid && r_pay.mem_read && (r_pay.waddr != 5'd0) && bus.in_valid &&
                      ((w_rs1_used && (w_rs1 == r_pay.waddr)) ||
                       (w_rs2_used && (w_rs2 == r_pay.waddr)));

  assign w_accept = bus.in_valid && !bus.flush && (!r_valid || bus.out_ready) && !w_load_use;

  // Flush beats accept; a free slot with nothing accepted drains to a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pay   <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pay   <= w_dec;
    end else if (!r_valid || bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready     = bus.flush || ((!r_valid || bus.out_ready) && !w_load_use);
  assign bus.hazard_stall = w_load_use && !bus.flush;
  assign bus.reg1_raddr   = w_rs1;
  assign bus.reg2_raddr   = w_rs2;

  assign bus.out_valid    = r_valid;
  assign bus.out_pc       = r_pay.pc;
  assign bus.alu_op       = r_pay.alu_op;
  assign bus.alu_src_sel  = r_pay.alu_src_sel;
  assign bus.reg1_data_o  = r_pay.rs1_data;
  assign bus.reg2_data_o  = r_pay.rs2_data;
  assign bus.imm_o        = r_pay.imm;
  assign bus.branch       = r_pay.branch;
  assign bus.jump         = r_pay.jump;
  assign bus.reg_wen      = r_pay.reg_wen;
  assign bus.mem_read     = r_pay.mem_read;
  assign bus.mem_write    = r_pay.mem_write;
  assign bus.ecall        = r_pay.ecall;
  assign bus.ebreak       = r_pay.ebreak;
  assign bus.fence        = r_pay.fence;
  assign bus.illegal      = r_pay.illegal;
  assign bus.reg_waddr    = r_pay.waddr;

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
// Directed stimulus with hand-computed expected payloads. The driver records
// the expected payload of each instruction it offers; an input monitor pushes
// it into a queue when the handshake completes, and an output monitor pops and
// compares whenever EX takes a payload. Cycle-exact handshake and stall
// behaviour is checked inline by the driver.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst_n;

  id_stage_pipe_if #(.XLEN(32)) bus();

  id_stage_pipe #(.XLEN(32), .FWD_WB(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [1:0]  src;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [8:0]  flags;  // branch jump reg_wen mem_read mem_write ecall ebreak fence illegal
    logic [4:0]  waddr;
  } exp_t;

  localparam logic [8:0] F_BR  = 9'b100000000;
  localparam logic [8:0] F_WEN = 9'b001000000;
  localparam logic [8:0] F_MRD = 9'b000100000;
  localparam logic [8:0] F_ILL = 9'b000000001;

  localparam logic [31:0] I_ADDI  = 32'hF0650513;  // addi a0,a0,-250
  localparam logic [31:0] I_LW    = 32'h00052F03;  // lw   t5,0(a0)
  localparam logic [31:0] I_ADD   = 32'h01EF0533;  // add  a0,t5,t5
  localparam logic [31:0] I_LUI   = 32'h123455B7;  // lui  a1,0x12345
  localparam logic [31:0] I_ADDI0 = 32'h00700293;  // addi t0,x0,7
  localparam logic [31:0] I_SRAI  = 32'h4035D593;  // srai a1,a1,3
  localparam logic [31:0] I_BEQ   = 32'h02208063;  // beq  x1,x2,+32
  localparam logic [31:0] I_ILL   = 32'h00000000;

  exp_t exp_q[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [147:0] act, input logic [147:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] alu, input logic [1:0] src,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                              input logic [8:0] flags, input logic [4:0] waddr);
    exp_t e;
    e.pc = pc; e.alu_op = alu; e.src = src; e.d1 = d1; e.d2 = d2;
    e.imm = imm; e.flags = flags; e.waddr = waddr;
    return e;
  endfunction

  function automatic exp_t got();
    exp_t g;
    g.pc     = bus.out_pc;
    g.alu_op = bus.alu_op;
    g.src    = bus.alu_src_sel;
    g.d1     = bus.reg1_data_o;
    g.d2     = bus.reg2_data_o;
    g.imm    = bus.imm_o;
    g.flags  = {bus.branch, bus.jump, bus.reg_wen, bus.mem_read, bus.mem_write,
                bus.ecall, bus.ebreak, bus.fence, bus.illegal};
    g.waddr  = bus.reg_waddr;
    return g;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2, input exp_t e);
    bus.in_valid     = v;
    bus.in_inst      = inst;
    bus.in_pc        = pc;
    bus.reg1_rdata_i = rd1;
    bus.reg2_rdata_i = rd2;
    cur_exp          = e;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_wen   = en;
    bus.wb_waddr = addr;
    bus.wb_wdata = data;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Input monitor: record the expected payload of every accepted instruction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && bus.flush === 1'b0)
      exp_q.push_back(cur_exp);
  end

  // Output monitor: compare every payload EX takes against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", got());
      end else begin
        check("payload", got(), exp_q.pop_front());
      end
    end
  end

  exp_t e_bp;

  initial begin
    // ---------------- reset with a valid instruction at the input ----------
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, I_ADDI, 32'h0, 32'h100, 32'h22, '0);
    cycle();
    cycle();
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_payload", got(), '0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);

    // ---------------- addi a0,a0,-250 ---------------------------------------
    drive(1'b1, I_ADDI, 32'h1000, 32'h100, 32'h22,
          mk(32'h1000, 4'd0, 2'b01, 32'h100, 32'h22, 32'hFFFFFF06, F_WEN, 5'd10));
    #1;
    check("addi_rs1_addr", bus.reg1_raddr, 5'd10);
    check("addi_in_ready", bus.in_ready, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    #1;
    check("addi_out_valid", bus.out_valid, 1'b1);
    cycle();
    check("idle_out_valid", bus.out_valid, 1'b0);

    // ---------------- load-use: lw t5 then add a0,t5,t5 ---------------------
    drive(1'b1, I_LW, 32'h1004, 32'h2000, 32'h77,
          mk(32'h1004, 4'd0, 2'b01, 32'h2000, 32'h0, 32'h0, F_WEN | F_MRD, 5'd30));
    cycle();
    drive(1'b1, I_ADD, 32'h1008, 32'h55, 32'h66,
          mk(32'h1008, 4'd0, 2'b00, 32'h55, 32'h66, 32'h0, F_WEN, 5'd10));
    #1;
    check("lu_stall", bus.hazard_stall, 1'b1);
    check("lu_in_ready", bus.in_ready, 1'b0);
    check("lu_lw_valid", bus.out_valid, 1'b1);
    cycle();
    check("lu_bubble", bus.out_valid, 1'b0);
    check("lu_stall_clear", bus.hazard_stall, 1'b0);
    check("lu_in_ready_back", bus.in_ready, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    #1;
    check("lu_add_valid", bus.out_valid, 1'b1);
    cycle();

    // ---------------- backpressure ------------------------------------------
    e_bp = mk(32'h2000, 4'd0, 2'b01, 32'h100, 32'h22, 32'hFFFFFF06, F_WEN, 5'd10);
    drive(1'b1, I_ADDI, 32'h2000, 32'h100, 32'h22, e_bp);
    cycle();
    drive(1'b1, I_LUI, 32'h2004, 32'h11, 32'h22,
          mk(32'h2004, 4'd10, 2'b01, 32'h11, 32'h22, 32'h12345000, F_WEN, 5'd11));
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", bus.in_ready, 1'b0);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_hold", got(), e_bp);
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    #1;
    check("bp_lui_valid", bus.out_valid, 1'b1);
    cycle();

    // ---------------- flush with lw held and add at input -------------------
    drive(1'b1, I_LW, 32'h3000, 32'h2000, 32'h77,
          mk(32'h3000, 4'd0, 2'b01, 32'h2000, 32'h0, 32'h0, F_WEN | F_MRD, 5'd30));
    cycle();
    drive(1'b1, I_ADD, 32'h3004, 32'h55, 32'h66,
          mk(32'h3004, 4'd0, 2'b00, 32'h55, 32'h66, 32'h0, F_WEN, 5'd10));
    bus.flush     = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    check("fl_no_stall", bus.hazard_stall, 1'b0);
    check("fl_in_ready", bus.in_ready, 1'b1);
    check("fl_lw_valid", bus.out_valid, 1'b1);
    cycle();
    // The killed lw never reaches EX.
    check("fl_queue_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    #1;
    check("fl_killed", bus.out_valid, 1'b0);
    cycle();
    check("fl_add_dropped", bus.out_valid, 1'b0);

    // ---------------- bypass, x0, shifts, branch, illegal (back-to-back) ----
    set_wb(1'b1, 5'd10, 32'hDEADBEEF);
    drive(1'b1, I_ADDI, 32'h4000, 32'h100, 32'h22,
          mk(32'h4000, 4'd0, 2'b01, 32'hDEADBEEF, 32'h22, 32'hFFFFFF06, F_WEN, 5'd10));
    cycle();
    set_wb(1'b1, 5'd0, 32'h00000BAD);
    drive(1'b1, I_ADDI0, 32'h4004, 32'h99, 32'h22,
          mk(32'h4004, 4'd0, 2'b01, 32'h0, 32'h22, 32'h7, F_WEN, 5'd5));
    cycle();
    set_wb(1'b1, 5'd10, 32'hDEADBEEF);
    drive(1'b1, I_SRAI, 32'h4008, 32'h11, 32'h22,
          mk(32'h4008, 4'd7, 2'b01, 32'h11, 32'h22, 32'h403, F_WEN, 5'd11));
    cycle();
    set_wb(1'b0, 5'd0, 32'h0);
    drive(1'b1, I_BEQ, 32'h400C, 32'h11, 32'h22,
          mk(32'h400C, 4'd1, 2'b00, 32'h11, 32'h22, 32'h20, F_BR, 5'd0));
    cycle();
    drive(1'b1, I_ILL, 32'h4010, 32'h11, 32'h22,
          mk(32'h4010, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, F_ILL, 5'd0));
    cycle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, '0);
    repeat (3) cycle();
    check("drained", exp_q.size(), 0);
    check("final_out_valid", bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
